// File: rtl/segre_wb_buffer.sv
// Line-granular write-back buffer between the MMU and main memory: a small FIFO
// of dirty lines, drained when no fill is waiting, that also answers fills it holds.
module segre_wb_buffer #(
    parameter int ADDR_SIZE      = 32,
    parameter int LANE_SIZE      = 128,
    parameter int LINE_BYTE_BITS = 4,
    parameter int WB_DEPTH       = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 mmu_wr_req_i,
    input  logic [ADDR_SIZE-1:0] mmu_wr_addr_i,
    input  logic [LANE_SIZE-1:0] mmu_wr_data_i,
    input  logic                 mmu_rd_req_i,
    input  logic [ADDR_SIZE-1:0] mmu_rd_addr_i,
    output logic                 mmu_data_rdy_o,
    output logic [LANE_SIZE-1:0] mmu_data_o,
    output logic                 wb_full_o,
    output logic                 wb_empty_o,
    output logic                 wb_overflow_o,
    output logic                 mem_rd_req_o,
    output logic                 mem_wr_req_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LANE_SIZE-1:0] mem_data_o,
    input  logic                 mem_data_rdy_i,
    input  logic [LANE_SIZE-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int TAG_W = ADDR_SIZE - LINE_BYTE_BITS;
    localparam int PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CNT_W = $clog2(WB_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);
    localparam logic [LINE_BYTE_BITS-1:0] OFFS_ZERO = {LINE_BYTE_BITS{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(WB_DEPTH - 1)) begin
            ptr_inc = PTR_W'(0);
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Buffer state
    logic [TAG_W-1:0]     buf_tag_q  [WB_DEPTH];
    logic [LANE_SIZE-1:0] buf_data_q [WB_DEPTH];
    logic [PTR_W-1:0]     head_q, tail_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 inflight_q;
    logic                 rd_pend_q;
    logic [TAG_W-1:0]     rd_tag_q;
    state_e               state_q;

    // Registered outputs
    logic                 mmu_data_rdy_q;
    logic [LANE_SIZE-1:0] mmu_data_q;
    logic                 wb_full_q, wb_empty_q, wb_overflow_q;
    logic                 mem_rd_req_q, mem_wr_req_q;
    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic [LANE_SIZE-1:0] mem_data_q;

    // Combinational control
    logic [TAG_W-1:0]     wr_tag_s, rd_tag_s, rd_line_s;
    logic                 rd_hit_s, wr_hit_s, rd_match_s, wr_match_s;
    logic [LANE_SIZE-1:0] rd_hit_data_s, head_data_s;
    logic [PTR_W-1:0]     wr_hit_idx_s, scan_idx_s;
    logic                 rd_acc_s, rd_miss_s, full_s;
    logic                 merge_s, push_s, drop_s, pop_s;
    logic                 rd_done_s, rd_go_s, wr_go_s;
    logic                 unused_s;

    assign wr_tag_s = mmu_wr_addr_i[ADDR_SIZE-1:LINE_BYTE_BITS];
    assign rd_tag_s = mmu_rd_addr_i[ADDR_SIZE-1:LINE_BYTE_BITS];
    assign unused_s = ^{mmu_wr_addr_i[LINE_BYTE_BITS-1:0], mmu_rd_addr_i[LINE_BYTE_BITS-1:0]};

    // Scan resident entries oldest to youngest so the last match is the youngest one
    always_comb begin
        rd_hit_s      = 1'b0;
        rd_hit_data_s = {LANE_SIZE{1'b0}};
        wr_hit_s      = 1'b0;
        wr_hit_idx_s  = PTR_W'(0);
        rd_match_s    = 1'b0;
        wr_match_s    = 1'b0;
        scan_idx_s    = head_q;
        for (int k = 0; k < WB_DEPTH; k++) begin
            rd_match_s    = (CNT_W'(k) < count_q) && (buf_tag_q[scan_idx_s] == rd_tag_s);
            wr_match_s    = (CNT_W'(k) < count_q) && (buf_tag_q[scan_idx_s] == wr_tag_s)
                            && !((k == 0) && inflight_q);
            rd_hit_s      = rd_hit_s | rd_match_s;
            rd_hit_data_s = rd_match_s ? buf_data_q[scan_idx_s] : rd_hit_data_s;
            wr_hit_s      = wr_hit_s | wr_match_s;
            wr_hit_idx_s  = wr_match_s ? scan_idx_s : wr_hit_idx_s;
            scan_idx_s    = ptr_inc(scan_idx_s);
        end
    end

    // Request classification, FSM launch decisions and occupancy update
    always_comb begin
        rd_acc_s  = mmu_rd_req_i && !rd_pend_q;
        rd_miss_s = rd_acc_s && !rd_hit_s;
        full_s    = (count_q == DEPTH_C);
        merge_s   = mmu_wr_req_i && wr_hit_s;
        push_s    = mmu_wr_req_i && !wr_hit_s && !full_s;
        drop_s    = mmu_wr_req_i && !wr_hit_s && full_s;
        pop_s     = (state_q == WR_WAIT) && mem_ack_i;
        rd_done_s = (state_q == RD_WAIT) && mem_data_rdy_i;
        rd_go_s   = (state_q == IDLE) && (rd_pend_q || rd_miss_s);
        wr_go_s   = (state_q == IDLE) && !rd_pend_q && !rd_miss_s && (count_q != CNT_W'(0));
        rd_line_s = rd_pend_q ? rd_tag_q : rd_tag_s;
        // A merge into the head on the cycle its drain launches must reach memory
        head_data_s = (merge_s && (wr_hit_idx_s == head_q)) ? mmu_wr_data_i : buf_data_q[head_q];
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, status flags and the pending-read latch
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                buf_tag_q[i]  <= {TAG_W{1'b0}};
                buf_data_q[i] <= {LANE_SIZE{1'b0}};
            end
            head_q        <= PTR_W'(0);
            tail_q        <= PTR_W'(0);
            count_q       <= CNT_W'(0);
            wb_full_q     <= 1'b0;
            wb_empty_q    <= 1'b1;
            wb_overflow_q <= 1'b0;
            rd_pend_q     <= 1'b0;
            rd_tag_q      <= {TAG_W{1'b0}};
        end else begin
            if (merge_s) begin
                buf_data_q[wr_hit_idx_s] <= mmu_wr_data_i;
            end
            if (push_s) begin
                buf_tag_q[tail_q]  <= wr_tag_s;
                buf_data_q[tail_q] <= mmu_wr_data_i;
                tail_q             <= ptr_inc(tail_q);
            end
            if (pop_s) begin
                head_q <= ptr_inc(head_q);
            end
            count_q    <= count_d;
            wb_full_q  <= (count_d == DEPTH_C);
            wb_empty_q <= (count_d == CNT_W'(0));
            if (drop_s) begin
                wb_overflow_q <= 1'b1;
            end
            if (rd_miss_s) begin
                rd_pend_q <= 1'b1;
                rd_tag_q  <= rd_tag_s;
            end else if (rd_done_s) begin
                rd_pend_q <= 1'b0;
            end
        end
    end

    // Memory-side FSM: reads beat drains, request pulses and held address/data
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q      <= IDLE;
            inflight_q   <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            mem_addr_q   <= {ADDR_SIZE{1'b0}};
            mem_data_q   <= {LANE_SIZE{1'b0}};
        end else begin
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rd_go_s) begin
                        state_q      <= RD_WAIT;
                        mem_rd_req_q <= 1'b1;
                        mem_addr_q   <= {rd_line_s, OFFS_ZERO};
                    end else if (wr_go_s) begin
                        state_q      <= WR_WAIT;
                        mem_wr_req_q <= 1'b1;
                        mem_addr_q   <= {buf_tag_q[head_q], OFFS_ZERO};
                        mem_data_q   <= head_data_s;
                        inflight_q   <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (rd_done_s) begin
                        state_q <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (pop_s) begin
                        state_q    <= IDLE;
                        inflight_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    inflight_q <= 1'b0;
                end
            endcase
        end
    end

    // Fill response to the MMU: memory data for a pending read, buffer data for a hit
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            mmu_data_rdy_q <= 1'b0;
            mmu_data_q     <= {LANE_SIZE{1'b0}};
        end else begin
            mmu_data_rdy_q <= 1'b0;
            if (rd_done_s) begin
                mmu_data_rdy_q <= 1'b1;
                mmu_data_q     <= mem_data_i;
            end else if (rd_acc_s && rd_hit_s) begin
                mmu_data_rdy_q <= 1'b1;
                mmu_data_q     <= rd_hit_data_s;
            end
        end
    end

    assign mmu_data_rdy_o = mmu_data_rdy_q;
    assign mmu_data_o     = mmu_data_q;
    assign wb_full_o      = wb_full_q;
    assign wb_empty_o     = wb_empty_q;
    assign wb_overflow_o  = wb_overflow_q;
    assign mem_rd_req_o   = mem_rd_req_q;
    assign mem_wr_req_o   = mem_wr_req_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;

endmodule

// File: tb/tb_segre_wb_buffer.sv
// Directed bench for segre_wb_buffer: a vector table for the main flow plus
// hand-written sequences for read priority, in-flight pushes and async reset.
module tb_segre_wb_buffer;

    logic         clk_i = 1'b0;
    logic         rsn_i = 1'b0;
    logic         mmu_wr_req_i, mmu_rd_req_i, mem_data_rdy_i, mem_ack_i;
    logic [31:0]  mmu_wr_addr_i, mmu_rd_addr_i;
    logic [127:0] mmu_wr_data_i, mem_data_i;
    logic         mmu_data_rdy_o, wb_full_o, wb_empty_o, wb_overflow_o;
    logic         mem_rd_req_o, mem_wr_req_o;
    logic [127:0] mmu_data_o, mem_data_o;
    logic [31:0]  mem_addr_o;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] D1 = {4{32'h1111_1111}};
    localparam logic [127:0] D2 = {4{32'h2222_2222}};
    localparam logic [127:0] D3 = {4{32'h3333_3333}};
    localparam logic [127:0] D5 = {4{32'h5555_5555}};
    localparam logic [127:0] D6 = {4{32'h6666_6666}};
    localparam logic [127:0] D7 = {4{32'h7777_7777}};
    localparam logic [127:0] D8 = {4{32'h8888_8888}};
    localparam logic [127:0] D9 = {4{32'h9999_9999}};

    segre_wb_buffer dut (
        .clk_i(clk_i), .rsn_i(rsn_i),
        .mmu_wr_req_i(mmu_wr_req_i), .mmu_wr_addr_i(mmu_wr_addr_i), .mmu_wr_data_i(mmu_wr_data_i),
        .mmu_rd_req_i(mmu_rd_req_i), .mmu_rd_addr_i(mmu_rd_addr_i),
        .mmu_data_rdy_o(mmu_data_rdy_o), .mmu_data_o(mmu_data_o),
        .wb_full_o(wb_full_o), .wb_empty_o(wb_empty_o), .wb_overflow_o(wb_overflow_o),
        .mem_rd_req_o(mem_rd_req_o), .mem_wr_req_o(mem_wr_req_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_rdy_i(mem_data_rdy_i), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         wr;
        logic [31:0]  wa;
        logic [127:0] wd;
        logic         rd;
        logic [31:0]  ra;
        logic         ack;
        logic         e_rdy;
        logic [127:0] e_dat;
        logic         e_full;
        logic         e_empty;
        logic         e_ovf;
        logic         e_mrd;
        logic         e_mwr;
        logic [31:0]  e_addr;
        logic [127:0] e_mdat;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic wr, input logic [31:0] wa, input logic [127:0] wd,
                                input logic rd, input logic [31:0] ra, input logic ack,
                                input logic e_rdy, input logic [127:0] e_dat,
                                input logic e_full, input logic e_empty, input logic e_ovf,
                                input logic e_mrd, input logic e_mwr,
                                input logic [31:0] e_addr, input logic [127:0] e_mdat);
        vec_t v;
        v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra; v.ack = ack;
        v.e_rdy = e_rdy; v.e_dat = e_dat; v.e_full = e_full; v.e_empty = e_empty;
        v.e_ovf = e_ovf; v.e_mrd = e_mrd; v.e_mwr = e_mwr; v.e_addr = e_addr; v.e_mdat = e_mdat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {127'd0, act}, {127'd0, exp});
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clr();
        mmu_wr_req_i = 1'b0; mmu_wr_addr_i = 32'h0; mmu_wr_data_i = 128'h0;
        mmu_rd_req_i = 1'b0; mmu_rd_addr_i = 32'h0;
        mem_data_rdy_i = 1'b0; mem_data_i = 128'h0; mem_ack_i = 1'b0;
    endtask

    task automatic rst();
        clr();
        rsn_i = 1'b0;
        step();
        rsn_i = 1'b1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d);
        mmu_wr_req_i = 1'b1; mmu_wr_addr_i = a; mmu_wr_data_i = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk1({tag, " mmu_rdy"}, mmu_data_rdy_o, 1'b0);
        chk1({tag, " mem_rd"}, mem_rd_req_o, 1'b0);
        chk1({tag, " mem_wr"}, mem_wr_req_o, 1'b0);
        chk1({tag, " full"}, wb_full_o, 1'b0);
        chk1({tag, " ovf"}, wb_overflow_o, 1'b0);
        chk1({tag, " empty"}, wb_empty_o, 1'b1);
        chk({tag, " mmu_data"}, mmu_data_o, 128'h0);
        chk({tag, " mem_addr"}, {96'd0, mem_addr_o}, 128'h0);
        chk({tag, " mem_data"}, mem_data_o, 128'h0);
    endtask

    initial begin
        //             wr  wa          wd  rd  ra        ack rdy dat full emp ovf mrd mwr addr      mdat
        tbl[0]  = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  1,  0,  0,  0, 32'h0,   0);
        tbl[1]  = mk(1, 32'h100, D1, 0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  0, 32'h0,   0);
        tbl[2]  = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  1, 32'h100, D1);
        tbl[3]  = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  0, 32'h0,   0);
        tbl[4]  = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  0, 32'h0,   0);
        tbl[5]  = mk(0, 32'h0,   0,  0, 32'h0,   1,  0, 0,  0,  1,  0,  0,  0, 32'h0,   0);
        tbl[6]  = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  1,  0,  0,  0, 32'h0,   0);
        tbl[7]  = mk(1, 32'h200, D2, 0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  0, 32'h0,   0);
        tbl[8]  = mk(0, 32'h0,   0,  1, 32'h208, 0,  1, D2, 0,  0,  0,  0,  1, 32'h200, D2);
        tbl[9]  = mk(0, 32'h0,   0,  1, 32'h20C, 0,  1, D2, 0,  0,  0,  0,  0, 32'h0,   0);
        tbl[10] = mk(1, 32'h500, D5, 0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  0, 32'h0,   0);
        tbl[11] = mk(1, 32'h600, D6, 0, 32'h0,   0,  0, 0,  0,  0,  0,  0,  0, 32'h0,   0);
        tbl[12] = mk(1, 32'h700, D7, 0, 32'h0,   0,  0, 0,  1,  0,  0,  0,  0, 32'h0,   0);
        tbl[13] = mk(1, 32'h800, D9, 0, 32'h0,   0,  0, 0,  1,  0,  1,  0,  0, 32'h0,   0);
        tbl[14] = mk(1, 32'h504, D8, 0, 32'h0,   0,  0, 0,  1,  0,  1,  0,  0, 32'h0,   0);
        tbl[15] = mk(0, 32'h0,   0,  1, 32'h500, 0,  1, D8, 1,  0,  1,  0,  0, 32'h0,   0);
        tbl[16] = mk(0, 32'h0,   0,  0, 32'h0,   1,  0, 0,  0,  0,  1,  0,  0, 32'h0,   0);
        tbl[17] = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  0,  1,  0,  1, 32'h500, D8);
        tbl[18] = mk(0, 32'h0,   0,  0, 32'h0,   1,  0, 0,  0,  0,  1,  0,  0, 32'h0,   0);
        tbl[19] = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  0,  1,  0,  1, 32'h600, D6);
        tbl[20] = mk(0, 32'h0,   0,  0, 32'h0,   1,  0, 0,  0,  0,  1,  0,  0, 32'h0,   0);
        tbl[21] = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  0,  1,  0,  1, 32'h700, D7);
        tbl[22] = mk(0, 32'h0,   0,  0, 32'h0,   1,  0, 0,  0,  1,  1,  0,  0, 32'h0,   0);
        tbl[23] = mk(0, 32'h0,   0,  0, 32'h0,   0,  0, 0,  0,  1,  1,  0,  0, 32'h0,   0);

        // Reset values while held in reset
        clr();
        step();
        step();
        chk_reset_outputs("reset");
        rsn_i = 1'b1;

        // Main table: single write/drain, hit forwarding, fill to full, drop, merge
        for (int i = 0; i < 24; i++) begin
            mmu_wr_req_i = tbl[i].wr; mmu_wr_addr_i = tbl[i].wa; mmu_wr_data_i = tbl[i].wd;
            mmu_rd_req_i = tbl[i].rd; mmu_rd_addr_i = tbl[i].ra; mem_ack_i = tbl[i].ack;
            step();
            clr();
            chk1($sformatf("v%0d mmu_rdy", i), mmu_data_rdy_o, tbl[i].e_rdy);
            if (tbl[i].e_rdy) chk($sformatf("v%0d mmu_data", i), mmu_data_o, tbl[i].e_dat);
            chk1($sformatf("v%0d full", i), wb_full_o, tbl[i].e_full);
            chk1($sformatf("v%0d empty", i), wb_empty_o, tbl[i].e_empty);
            chk1($sformatf("v%0d ovf", i), wb_overflow_o, tbl[i].e_ovf);
            chk1($sformatf("v%0d mem_rd", i), mem_rd_req_o, tbl[i].e_mrd);
            chk1($sformatf("v%0d mem_wr", i), mem_wr_req_o, tbl[i].e_mwr);
            if (tbl[i].e_mrd || tbl[i].e_mwr)
                chk($sformatf("v%0d mem_addr", i), {96'd0, mem_addr_o}, {96'd0, tbl[i].e_addr});
            if (tbl[i].e_mwr) chk($sformatf("v%0d mem_data", i), mem_data_o, tbl[i].e_mdat);
        end

        // Read miss during WR_WAIT is issued after the ack, ahead of the second drain
        rst();
        wr(32'h100, D1); step(); clr();
        wr(32'h140, D2); step(); clr();
        chk1("A drain1 req", mem_wr_req_o, 1'b1);
        mmu_rd_req_i = 1'b1; mmu_rd_addr_i = 32'h304; step(); clr();
        chk1("A no rd in WR_WAIT", mem_rd_req_o, 1'b0);
        chk1("A miss no rdy", mmu_data_rdy_o, 1'b0);
        step();
        mem_ack_i = 1'b1; step(); clr();
        chk1("A ack cycle no rd", mem_rd_req_o, 1'b0);
        step();
        chk1("A rd req", mem_rd_req_o, 1'b1);
        chk1("A rd not wr", mem_wr_req_o, 1'b0);
        chk("A rd addr", {96'd0, mem_addr_o}, {96'd0, 32'h300});
        step();
        chk1("A addr held no wr", mem_wr_req_o, 1'b0);
        chk("A rd addr held", {96'd0, mem_addr_o}, {96'd0, 32'h300});
        mem_data_rdy_i = 1'b1; mem_data_i = D3; step(); clr();
        chk1("A fill rdy", mmu_data_rdy_o, 1'b1);
        chk("A fill data", mmu_data_o, D3);
        step();
        chk1("A fill pulse", mmu_data_rdy_o, 1'b0);
        chk1("A drain2 req", mem_wr_req_o, 1'b1);
        chk("A drain2 addr", {96'd0, mem_addr_o}, {96'd0, 32'h140});
        chk("A drain2 data", mem_data_o, D2);

        // Write to the in-flight head line pushes a new entry; reads see the new data
        rst();
        wr(32'h400, D1); step(); clr();
        step();
        chk1("B drain req", mem_wr_req_o, 1'b1);
        chk("B drain data", mem_data_o, D1);
        wr(32'h400, D2); step(); clr();
        chk1("B not full", wb_full_o, 1'b0);
        mmu_rd_req_i = 1'b1; mmu_rd_addr_i = 32'h400; step(); clr();
        chk1("B fwd rdy", mmu_data_rdy_o, 1'b1);
        chk("B fwd data", mmu_data_o, D2);
        mem_ack_i = 1'b1; step(); clr();
        chk1("B still one entry", wb_empty_o, 1'b0);
        step();
        chk1("B second drain", mem_wr_req_o, 1'b1);
        chk("B second addr", {96'd0, mem_addr_o}, {96'd0, 32'h400});
        chk("B second data", mem_data_o, D2);
        mem_ack_i = 1'b1; step(); clr();
        chk1("B empty", wb_empty_o, 1'b1);

        // Async reset during RD_WAIT with three entries buffered
        rst();
        wr(32'h100, D1); mmu_rd_req_i = 1'b1; mmu_rd_addr_i = 32'h900; step(); clr();
        chk1("C miss rd req", mem_rd_req_o, 1'b1);
        chk("C miss addr", {96'd0, mem_addr_o}, {96'd0, 32'h900});
        wr(32'h140, D2); step(); clr();
        wr(32'h180, D3); step(); clr();
        chk1("C not empty", wb_empty_o, 1'b0);
        chk1("C no drain in RD_WAIT", mem_wr_req_o, 1'b0);
        #3 rsn_i = 1'b0;
        #1 chk_reset_outputs("C async");
        #2 rsn_i = 1'b1;
        mem_data_rdy_i = 1'b1; mem_data_i = D3; step(); clr();
        chk1("C late rdy ignored", mmu_data_rdy_o, 1'b0);
        step();
        step();
        chk1("C no drain", mem_wr_req_o, 1'b0);
        chk1("C no rd", mem_rd_req_o, 1'b0);
        chk1("C empty", wb_empty_o, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
